// File: rtl/core_pkg.sv
// core_pkg: shared pipeline-control types and constants for the 5-stage core.
package core_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int CNT_WIDTH_DEF = 16;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: synchronous-clear counter that sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush, memory freeze and halt/drain sequencing.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_q2_i,
  input  logic [4:0]           rs2_q2_i,
  input  logic                 rs1_used_q2_i,
  input  logic                 rs2_used_q2_i,
  input  logic [4:0]           rd_q3_i,
  input  logic                 mem_re_q3_i,
  input  logic                 branch_taken_q4_i,
  input  logic                 mem_busy_i,
  input  logic                 halt_req_i,
  output logic                 pc_we_o,
  output logic                 pc_sel_target_o,
  output logic                 q1q2_we_o,
  output logic                 q1q2_flush_o,
  output logic                 q2q3_flush_o,
  output logic                 q3q4_flush_o,
  output logic                 pipe_we_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_drain, w_drain_nxt;
  logic          r_halted, w_freeze, w_hit, w_branch, w_lu;
  always_comb begin
    w_freeze    = mem_busy_i;
    w_hit       = mem_re_q3_i && rd_q3_i != '0 &&
                  ((rs1_used_q2_i && rs1_q2_i == rd_q3_i) || (rs2_used_q2_i && rs2_q2_i == rd_q3_i));
    w_branch    = !w_freeze && r_state != HALTED && branch_taken_q4_i;
    w_lu        = !w_freeze && r_state != HALTED && !branch_taken_q4_i && w_hit;
    w_drain_nxt = w_branch ? DW'(1) : w_lu ? r_drain : r_drain + 1'b1;
    w_state_nxt = r_state;
    if (!w_freeze)
      case (r_state)
        RUN:     if (halt_req_i && !w_branch) w_state_nxt = DRAIN;
        DRAIN:   w_state_nxt = !halt_req_i ? RUN : (w_drain_nxt == DW'(DRAIN_CYCLES)) ? HALTED : DRAIN;
        HALTED:  if (!halt_req_i) w_state_nxt = RUN;
        default: w_state_nxt = RUN;
      endcase
    // reset forces every register to flush with all enables low
    pc_we_o         = !rst && !w_freeze && (w_branch || (!w_lu && r_state == RUN));
    pc_sel_target_o = !rst && w_branch;
    q1q2_we_o       = !rst && !w_freeze && !w_lu;
    q1q2_flush_o    = rst || (!w_freeze && (w_branch || (!w_lu && r_state != RUN)));
    q2q3_flush_o    = rst || w_branch || w_lu;
    q3q4_flush_o    = rst || w_branch;
    pipe_we_o       = !rst && !w_freeze;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= RUN;
      r_drain  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_drain  <= r_state != DRAIN ? '0 : w_freeze ? r_drain : w_drain_nxt;
      r_halted <= w_state_nxt == HALTED;
    end
  assign halted_o = r_halted;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (.clk(clk), .clr(rst), .inc(w_lu), .cnt(stall_cnt_o));
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (.clk(clk), .clr(rst), .inc(w_branch), .cnt(flush_cnt_o));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl stalls, flushes, freeze, drain/halt and counters.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst, rs1_used, rs2_used, mem_re, br, busy, halt;
  logic [4:0]  rs1, rs2, rd;
  logic        pc_we, pc_sel, q12_we, f12, f23, f34, pipe_we, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_we, s_pc_sel, s_q12_we, s_f12, s_f23, s_f34, s_pipe_we, s_halted;
  logic [1:0]  s_stall, s_flush;
  int          n_asserts = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .rs1_q2_i(rs1), .rs2_q2_i(rs2), .rs1_used_q2_i(rs1_used),
    .rs2_used_q2_i(rs2_used), .rd_q3_i(rd), .mem_re_q3_i(mem_re), .branch_taken_q4_i(br),
    .mem_busy_i(busy), .halt_req_i(halt), .pc_we_o(pc_we), .pc_sel_target_o(pc_sel),
    .q1q2_we_o(q12_we), .q1q2_flush_o(f12), .q2q3_flush_o(f23), .q3q4_flush_o(f34),
    .pipe_we_o(pipe_we), .halted_o(halted), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  hazard_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .rs1_q2_i(rs1), .rs2_q2_i(rs2), .rs1_used_q2_i(rs1_used),
    .rs2_used_q2_i(rs2_used), .rd_q3_i(rd), .mem_re_q3_i(mem_re), .branch_taken_q4_i(br),
    .mem_busy_i(busy), .halt_req_i(halt), .pc_we_o(s_pc_we), .pc_sel_target_o(s_pc_sel),
    .q1q2_we_o(s_q12_we), .q1q2_flush_o(s_f12), .q2q3_flush_o(s_f23), .q3q4_flush_o(s_f34),
    .pipe_we_o(s_pipe_we), .halted_o(s_halted), .stall_cnt_o(s_stall), .flush_cnt_o(s_flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // control vector order: pc_we, pc_sel, q1q2_we, q1q2_flush, q2q3_flush, q3q4_flush, pipe_we
  task automatic ctl(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {25'b0, pc_we, pc_sel, q12_we, f12, f23, f34, pipe_we}, {25'b0, exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {rs1, rs2, rd} = '0;
    {rs1_used, rs2_used, mem_re, br, busy} = '0;
  endtask

  task automatic load_use;
    mem_re = 1'b1; rd = 5'd1; rs1 = 5'd1; rs1_used = 1'b1; rs2 = 5'd4; rs2_used = 1'b1;
  endtask

  initial begin
    idle();
    halt = 1'b0;
    rst = 1'b1;
    ctl("rst_ctl", 7'b0001110);
    tick();
    tick();
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_stall", {16'b0, stall_cnt}, 0);
    chk("rst_flush", {16'b0, flush_cnt}, 0);
    rst = 1'b0;
    ctl("run_idle", 7'b1010001);
    load_use();
    ctl("lu_rs1", 7'b0000101);
    tick();
    idle();
    ctl("lu_bubble", 7'b1010001);
    chk("lu_stall1", {16'b0, stall_cnt}, 1);
    mem_re = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1;
    ctl("lu_x0", 7'b1010001);
    tick();
    chk("lu_x0_cnt", {16'b0, stall_cnt}, 1);
    rd = 5'd5; rs1 = 5'd1; rs2 = 5'd5; rs2_used = 1'b0;
    ctl("lu_rs2_unused", 7'b1010001);
    tick();
    rs2_used = 1'b1;
    ctl("lu_rs2", 7'b0000101);
    tick();
    chk("lu_stall2", {16'b0, stall_cnt}, 2);
    idle();
    load_use();
    br = 1'b1;
    ctl("branch", 7'b1111111);
    tick();
    idle();
    chk("br_flush1", {16'b0, flush_cnt}, 1);
    chk("br_stall_ign", {16'b0, stall_cnt}, 2);
    busy = 1'b1; br = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ctl("freeze", 7'b0000000);
      tick();
    end
    chk("freeze_cnt", {16'b0, flush_cnt}, 1);
    busy = 1'b0;
    ctl("freeze_branch", 7'b1111111);
    tick();
    chk("br_flush2", {16'b0, flush_cnt}, 2);
    idle();
    busy = 1'b1; halt = 1'b1;
    ctl("freeze_halt", 7'b0000000);
    tick();
    busy = 1'b0;
    ctl("halt_deferred", 7'b1010001);
    tick();
    ctl("drain1", 7'b0011001);
    tick();
    br = 1'b1;
    ctl("drain_branch", 7'b1111111);
    tick();
    idle();
    load_use();
    ctl("drain_lu", 7'b0000101);
    tick();
    idle();
    ctl("drain4", 7'b0011001);
    tick();
    tick();
    chk("drain5_halted", {31'b0, halted}, 0);
    tick();
    chk("drain6_halted", {31'b0, halted}, 1);
    chk("drain_flush3", {16'b0, flush_cnt}, 3);
    chk("drain_stall3", {16'b0, stall_cnt}, 3);
    load_use();
    br = 1'b1;
    ctl("halted_ignore", 7'b0011001);
    tick();
    idle();
    chk("halted_flush", {16'b0, flush_cnt}, 3);
    chk("halted_stall", {16'b0, stall_cnt}, 3);
    halt = 1'b0;
    ctl("halted_exit", 7'b0011001);
    chk("halted_still", {31'b0, halted}, 1);
    tick();
    chk("unhalted", {31'b0, halted}, 0);
    ctl("rerun", 7'b1010001);
    halt = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("drain_seq_halted", {31'b0, halted}, 0);
      ctl("drain_seq", 7'b0011001);
      tick();
    end
    chk("halted_n5", {31'b0, halted}, 1);
    halt = 1'b0;
    tick();
    ctl("resume_pc", 7'b1010001);
    load_use();
    tick();
    idle();
    tick();
    load_use();
    tick();
    idle();
    chk("stall5", {16'b0, stall_cnt}, 5);
    chk("sat_stall", {30'b0, s_stall}, 3);
    chk("sat_flush", {30'b0, s_flush}, 3);
    halt = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    ctl("rst_drain", 7'b0001110);
    tick();
    rst = 1'b0;
    halt = 1'b0;
    chk("rst2_stall", {16'b0, stall_cnt}, 0);
    chk("rst2_flush", {16'b0, flush_cnt}, 0);
    chk("rst2_halted", {31'b0, halted}, 0);
    ctl("rst2_run", 7'b1010001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
